search_step_controller: RTL and testbench



---
 rtl/search_pkg.sv | 23 ++
 rtl/clause_popcount.sv | 23 ++
 rtl/search_step_controller.sv | 174 +++++++++++++++++
 tb/tb_search_step_controller.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/search_pkg.sv
// rtl/search_pkg.sv - shared state encoding and default sizing for the search blocks
//
// Purpose: common definitions for the search step controller and the
// stochastic search stage it drives.
// Contents: search_state_t (controller FSM states) and default widths.
package search_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_DONE   = 3'd4
  } search_state_t;

  localparam int DEFAULT_INT_INDEX_WIDTH    = 1;
  localparam int DEFAULT_BOOL_INDEX_WIDTH   = 1;
  localparam int DEFAULT_INT_WIDTH          = 4;
  localparam int DEFAULT_CLAUSE_INDEX_WIDTH = 2;
  localparam int DEFAULT_ITERATION_WIDTH    = 8;
  localparam int DEFAULT_WATCHDOG_WIDTH     = 8;

endpackage

// File: rtl/clause_popcount.sv
// rtl/clause_popcount.sv - counts the valid clauses in a clause mask
//
// Purpose: population count of the clause-valid mask. The result is the
// satisfied-clause target that marks a run as solved.
// Ports:
//   mask   in   NC  clause-valid mask
//   count  out  CW  number of set bits in mask
module clause_popcount #(
  parameter int NC = 4,
  parameter int CW = 3
) (
  input  logic [NC-1:0] mask,
  output logic [CW-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < NC; i++) begin
      count = count + CW'(mask[i]);
    end
  end

endmodule

// File: rtl/search_step_controller.sv
// rtl/search_step_controller.sv - iterates the stochastic search stage until solved, out of budget or stalled
//
// Purpose: holds the committed assignment, issues one search step at a time,
// commits the best candidate move each step and stops when all valid clauses
// are satisfied, the iteration budget is spent, or the search stage stalls.
// Ports:
//   in_clk, in_reset                clock, asynchronous active-high reset
//   in_start                        start pulse (accepted only in IDLE/DONE)
//   in_seed_integer/_boolean        initial assignment
//   in_existing_clauses             clause-valid mask (sets the solve target)
//   in_max_iterations               iteration budget (0 behaves as 1)
//   in_search_ready                 search stage step complete
//   in_best_gain                    satisfied-clause count of best move
//   in_best_assignment_integer/_boolean  best candidate assignment
//   out_search_enable               search stage run enable
//   out_current_integer/_boolean    committed assignment
//   out_iteration_count             commits so far (saturating)
//   out_busy, out_done, out_solved, out_timeout  run status
module search_step_controller
  import search_pkg::*;
#(
  parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = DEFAULT_INT_INDEX_WIDTH,
  parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = DEFAULT_BOOL_INDEX_WIDTH,
  parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE       = DEFAULT_INT_WIDTH,
  parameter int MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX          = DEFAULT_CLAUSE_INDEX_WIDTH,
  parameter int ITERATION_COUNT_WIDTH                       = DEFAULT_ITERATION_WIDTH,
  parameter int WATCHDOG_WIDTH                              = DEFAULT_WATCHDOG_WIDTH,
  localparam int NI = 2 ** MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX,
  localparam int NB = 2 ** MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX,
  localparam int WI = MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE,
  localparam int NC = 2 ** MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX,
  localparam int CW = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX + 1,
  localparam int IW = ITERATION_COUNT_WIDTH,
  localparam int WW = WATCHDOG_WIDTH
) (
  input  logic             in_clk,
  input  logic             in_reset,
  input  logic             in_start,
  input  logic [NI*WI-1:0] in_seed_integer,
  input  logic [NB-1:0]    in_seed_boolean,
  input  logic [NC-1:0]    in_existing_clauses,
  input  logic [IW-1:0]    in_max_iterations,
  input  logic             in_search_ready,
  input  logic [CW-1:0]    in_best_gain,
  input  logic [NI*WI-1:0] in_best_assignment_integer,
  input  logic [NB-1:0]    in_best_assignment_boolean,
  output logic             out_search_enable,
  output logic [NI*WI-1:0] out_current_integer,
  output logic [NB-1:0]    out_current_boolean,
  output logic [IW-1:0]    out_iteration_count,
  output logic             out_busy,
  output logic             out_done,
  output logic             out_solved,
  output logic             out_timeout
);

  search_state_t state, state_next;

  logic [NI*WI-1:0] cur_int;
  logic [NB-1:0]    cur_bool;
  logic [IW-1:0]    count, count_inc, budget;
  logic [CW-1:0]    target, gain_reg, clause_count;
  logic [WW-1:0]    watchdog, watchdog_inc;
  logic             solved, timeout;
  logic             start_ok, wd_expire, commit_solved, commit_exhaust;

  clause_popcount #(
    .NC(NC),
    .CW(CW)
  ) u_clause_popcount (
    .mask (in_existing_clauses),
    .count(clause_count)
  );

  assign start_ok       = in_start && (state == ST_IDLE || state == ST_DONE);
  assign watchdog_inc   = watchdog + WW'(1);
  // Stall is declared when the incremented watchdog would reach all-ones.
  assign wd_expire      = (watchdog_inc == {WW{1'b1}});
  assign count_inc      = (count == {IW{1'b1}}) ? count : count + IW'(1);
  // An empty clause set is trivially satisfied whatever gain is reported.
  assign commit_solved  = (gain_reg == target) || (target == '0);
  assign commit_exhaust = (count_inc == budget);

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next        = state;
    out_search_enable = 1'b0;
    out_busy          = 1'b0;
    out_done          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok) state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        out_search_enable = 1'b1;
        out_busy          = 1'b1;
        state_next        = ST_WAIT;
      end
      ST_WAIT: begin
        out_search_enable = 1'b1;
        out_busy          = 1'b1;
        if (in_search_ready) state_next = ST_COMMIT;
        else if (wd_expire)  state_next = ST_DONE;
      end
      ST_COMMIT: begin
        out_busy = 1'b1;
        // Solved is checked first so a final-iteration solve reports solved.
        if (commit_solved || commit_exhaust) state_next = ST_DONE;
        else                                 state_next = ST_ISSUE;
      end
      ST_DONE: begin
        out_done = 1'b1;
        if (start_ok) state_next = ST_ISSUE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      cur_int  <= '0;
      cur_bool <= '0;
      count    <= '0;
      budget   <= '0;
      target   <= '0;
      gain_reg <= '0;
      watchdog <= '0;
      solved   <= 1'b0;
      timeout  <= 1'b0;
    end else if (start_ok) begin
      cur_int  <= in_seed_integer;
      cur_bool <= in_seed_boolean;
      target   <= clause_count;
      budget   <= (in_max_iterations == '0) ? IW'(1) : in_max_iterations;
      count    <= '0;
      watchdog <= '0;
      solved   <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      case (state)
        ST_ISSUE: watchdog <= '0;
        ST_WAIT: begin
          if (in_search_ready) begin
            cur_int  <= in_best_assignment_integer;
            cur_bool <= in_best_assignment_boolean;
            gain_reg <= in_best_gain;
          end else begin
            watchdog <= watchdog_inc;
            if (wd_expire) timeout <= 1'b1;
          end
        end
        ST_COMMIT: begin
          count <= count_inc;
          if (commit_solved) solved <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_current_integer = cur_int;
  assign out_current_boolean = cur_bool;
  assign out_iteration_count = count;
  assign out_solved          = solved;
  assign out_timeout         = timeout;

endmodule

// File: tb/tb_search_step_controller.sv
// tb/tb_search_step_controller.sv - randomized self-checking bench for search_step_controller
module tb_search_step_controller;

  logic       in_clk = 1'b0;
  logic       in_reset = 1'b1;
  logic       in_start = 1'b0;
  logic [7:0] in_seed_integer = '0;
  logic [1:0] in_seed_boolean = '0;
  logic [3:0] in_existing_clauses = '0;
  logic [7:0] in_max_iterations = '0;
  logic       in_search_ready = 1'b0;
  logic [2:0] in_best_gain = '0;
  logic [7:0] in_best_assignment_integer = '0;
  logic [1:0] in_best_assignment_boolean = '0;
  logic       out_search_enable;
  logic [7:0] out_current_integer;
  logic [1:0] out_current_boolean;
  logic [7:0] out_iteration_count;
  logic       out_busy, out_done, out_solved, out_timeout;

  search_step_controller dut (
    .in_clk                    (in_clk),
    .in_reset                  (in_reset),
    .in_start                  (in_start),
    .in_seed_integer           (in_seed_integer),
    .in_seed_boolean           (in_seed_boolean),
    .in_existing_clauses       (in_existing_clauses),
    .in_max_iterations         (in_max_iterations),
    .in_search_ready           (in_search_ready),
    .in_best_gain              (in_best_gain),
    .in_best_assignment_integer(in_best_assignment_integer),
    .in_best_assignment_boolean(in_best_assignment_boolean),
    .out_search_enable         (out_search_enable),
    .out_current_integer       (out_current_integer),
    .out_current_boolean       (out_current_boolean),
    .out_iteration_count       (out_iteration_count),
    .out_busy                  (out_busy),
    .out_done                  (out_done),
    .out_solved                (out_solved),
    .out_timeout               (out_timeout)
  );

  always #5 in_clk = ~in_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Per-iteration behaviour of the emulated search stage.
  int         plan_delay[64];
  logic [2:0] plan_gain[64];
  logic [7:0] plan_bi[64];
  logic [1:0] plan_bb[64];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic fill_plan(input int delay, input logic [2:0] gain);
    for (int i = 0; i < 64; i++) begin
      plan_delay[i] = delay;
      plan_gain[i]  = gain;
      plan_bi[i]    = 8'($urandom);
      plan_bb[i]    = 2'($urandom);
    end
  endtask

  task automatic run_case(input string name, input logic [7:0] si, input logic [1:0] sb,
                          input logic [3:0] mask, input logic [7:0] budget,
                          input bit hold_issue, input bit mid_start);
    int target, bud, k, exp_cnt, exp_issues, exp_en;
    bit exp_solved, exp_to;
    logic [7:0] exp_ci;
    logic [1:0] exp_cb;
    int issues, en_cycles, wait_cnt, iter, cyc;
    bit prev_en;

    // Reference: walk the iterations as the search stage will answer them.
    target = $countones(mask);
    bud = (budget == 0) ? 1 : int'(budget);
    exp_ci = si; exp_cb = sb; k = 0;
    exp_solved = 0; exp_to = 0; exp_issues = 0; exp_en = 0;
    while (1) begin
      exp_issues++;
      if (plan_delay[k] >= 255) begin
        exp_to = 1;
        exp_en += 256;
        break;
      end
      exp_en += plan_delay[k] + 2;
      exp_ci = plan_bi[k];
      exp_cb = plan_bb[k];
      k++;
      if (int'(plan_gain[k-1]) == target || target == 0) begin
        exp_solved = 1;
        break;
      end
      if (k == bud) break;
    end
    exp_cnt = (k > 255) ? 255 : k;

    @(negedge in_clk);
    in_seed_integer = si;
    in_seed_boolean = sb;
    in_existing_clauses = mask;
    in_max_iterations = budget;
    in_start = 1'b1;
    @(negedge in_clk);
    in_start = 1'b0;
    issues = 0; en_cycles = 0; wait_cnt = 0; iter = 0; cyc = 0; prev_en = 0;
    while (!out_done && cyc < 3000) begin
      in_search_ready = 1'b0;
      in_start = 1'b0;
      in_seed_integer = si;
      if (out_search_enable) en_cycles++;
      if (out_search_enable && !prev_en) begin
        issues++;
        wait_cnt = 0;
        if (hold_issue) begin
          in_search_ready = 1'b1;
          in_best_gain = 3'(target);
          in_best_assignment_integer = 8'hEE;
          in_best_assignment_boolean = 2'b11;
        end
      end else if (out_search_enable) begin
        if (iter < 64 && wait_cnt == plan_delay[iter]) begin
          in_search_ready = 1'b1;
          in_best_gain = plan_gain[iter];
          in_best_assignment_integer = plan_bi[iter];
          in_best_assignment_boolean = plan_bb[iter];
          iter++;
        end
        if (mid_start && wait_cnt == 1) begin
          in_start = 1'b1;
          in_seed_integer = ~si;
        end
        wait_cnt++;
      end
      prev_en = out_search_enable;
      @(negedge in_clk);
      cyc++;
    end
    in_search_ready = 1'b0;
    in_start = 1'b0;
    if (cyc >= 3000) check({name, ".bound"}, 32'(cyc), 32'd0);
    check({name, ".done"},    32'(out_done), 32'd1);
    check({name, ".busy"},    32'(out_busy), 32'd0);
    check({name, ".solved"},  32'(out_solved), 32'(exp_solved));
    check({name, ".timeout"}, 32'(out_timeout), 32'(exp_to));
    check({name, ".count"},   32'(out_iteration_count), 32'(exp_cnt));
    check({name, ".cur_int"}, 32'(out_current_integer), 32'(exp_ci));
    check({name, ".cur_bool"},32'(out_current_boolean), 32'(exp_cb));
    check({name, ".issues"},  32'(issues), 32'(exp_issues));
    check({name, ".en_cyc"},  32'(en_cycles), 32'(exp_en));
    repeat (3) @(negedge in_clk);
    check({name, ".done_hold"},  32'(out_done), 32'd1);
    check({name, ".count_hold"}, 32'(out_iteration_count), 32'(exp_cnt));
    check({name, ".en_hold"},    32'(out_search_enable), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge in_clk);
    check("rst.enable", 32'(out_search_enable), 32'd0);
    check("rst.busy",   32'(out_busy), 32'd0);
    check("rst.done",   32'(out_done), 32'd0);
    check("rst.solved", 32'(out_solved), 32'd0);
    check("rst.timeout",32'(out_timeout), 32'd0);
    check("rst.count",  32'(out_iteration_count), 32'd0);
    check("rst.cur",    32'({out_current_integer, out_current_boolean}), 32'd0);
    in_reset = 1'b0;

    // Single commit that satisfies all four clauses.
    fill_plan(2, 3'd4);
    plan_bi[0] = 8'h23; plan_bb[0] = 2'b01;
    run_case("solve1", 8'h11, 2'b10, 4'b1111, 8'd5, 0, 0);

    // Never reaches the target: budget of 5 exhausted.
    fill_plan(2, 3'd3);
    run_case("budget5", 8'h11, 2'b10, 4'b1111, 8'd5, 0, 0);

    // Search stage never answers.
    fill_plan(1000, 3'd4);
    run_case("timeout", 8'h11, 2'b10, 4'b1111, 8'd5, 0, 0);

    // Start pulse while waiting is ignored.
    fill_plan(3, 3'd3);
    run_case("midstart", 8'h11, 2'b10, 4'b1111, 8'd5, 0, 1);

    // Zero budget runs exactly one iteration.
    fill_plan(1, 3'd3);
    run_case("budget0", 8'h11, 2'b10, 4'b1111, 8'd0, 0, 0);

    // No clauses, and a ready during ISSUE must not commit.
    fill_plan(2, 3'd3);
    run_case("noclause", 8'h11, 2'b10, 4'b0000, 8'd5, 1, 0);

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 64; i++) begin
        plan_delay[i] = ($urandom_range(0, 39) == 0) ? 1000 : int'($urandom_range(0, 5));
        plan_gain[i]  = 3'($urandom_range(0, 4));
        plan_bi[i]    = 8'($urandom);
        plan_bb[i]    = 2'($urandom);
      end
      run_case($sformatf("rand%0d", r), 8'($urandom), 2'($urandom), 4'($urandom),
               8'($urandom_range(0, 8)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    // Reset while the stage is enabled and waiting.
    fill_plan(1000, 3'd0);
    @(negedge in_clk);
    in_seed_integer = 8'h5A;
    in_seed_boolean = 2'b11;
    in_existing_clauses = 4'b1111;
    in_max_iterations = 8'd5;
    in_start = 1'b1;
    @(negedge in_clk);
    in_start = 1'b0;
    repeat (4) @(negedge in_clk);
    check("midwait.enable_pre", 32'(out_search_enable), 32'd1);
    check("midwait.cur_pre",    32'(out_current_integer), 32'h5A);
    #2 in_reset = 1'b1;
    #1;
    check("midwait.enable", 32'(out_search_enable), 32'd0);
    check("midwait.busy",   32'(out_busy), 32'd0);
    check("midwait.done",   32'(out_done), 32'd0);
    check("midwait.cur",    32'({out_current_integer, out_current_boolean}), 32'd0);
    check("midwait.count",  32'(out_iteration_count), 32'd0);
    @(negedge in_clk);
    in_reset = 1'b0;
    @(negedge in_clk);
    check("idle.busy", 32'(out_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
